dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the core's data-memory port.
- Accepts the core's address, 4-bit byte-write strobes and four byte lanes. Returns read data on the core's data input.
- Backs a word-addressed on-chip RAM region with 1-cycle read latency.
- Forwards accesses in the MMIO region to a req/ack peripheral bus, stalling the core with dmem_wait until the access completes.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of 2; RAM spans byte addresses 0 to DEPTH_WORDS*4-1.
- MMIO_BASE, 32'h0001_0000: first byte address of the MMIO region; the region extends to 32'hFFFF_FFFF.
- TIMEOUT, 16: maximum cycles to wait for mmio_ack; only used with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_addr  in  32  byte address from the core.
- datamem_wr  in  4  byte-write strobes; bit i writes lane i.
- data_out0  in  8  write data, lane 0 (bits 7:0).
- data_out1  in  8  write data, lane 1 (bits 15:8).
- data_out2  in  8  write data, lane 2 (bits 23:16).
- data_out3  in  8  write data, lane 3 (bits 31:24).
- data_in  out  32  read data to the core.
- dmem_wait  out  1  stall request to the core.
- mmio_req  out  1  peripheral request.
- mmio_we  out  4  peripheral byte strobes; 0 means read.
- mmio_addr  out  32  peripheral address.
- mmio_wdata  out  32  peripheral write data.
- mmio_rdata  in  32  peripheral read data; valid with mmio_ack.
- mmio_ack  in  1  peripheral completion, single-cycle pulse.
- err  out  1  one-cycle access-error pulse.

Behaviour:
- Reset: data_in=0, dmem_wait=0, mmio_req=0, mmio_we=0, mmio_addr=0, mmio_wdata=0, err=0, FSM=IDLE. RAM contents are not reset.
- Region decode uses data_addr every cycle:
  - RAM when data_addr < DEPTH_WORDS*4.
  - MMIO when data_addr >= MMIO_BASE.
  - Otherwise HOLE.
- Word index is data_addr[log2(DEPTH_WORDS)+1:2]. data_addr[1:0] is ignored; the core performs lane alignment.
- RAM write: on the rising edge, lane i of the addressed word is updated when datamem_wr[i]=1. No lane change occurs when all strobes are 0.
- RAM read: data_in at cycle n+1 equals the word at the cycle-n address.
  - Write-first: if a write occurs in cycle n, the updated lanes appear in data_in at n+1 and untouched lanes keep their old values.
- HOLE:
  - Writes are dropped; data_in is 0 next cycle.
  - err pulses for 1 cycle after any HOLE access, read or write.
- MMIO FSM, states IDLE, REQ, DONE:
  - IDLE: when the region is MMIO, dmem_wait=1 combinationally in the same cycle. Latch mmio_addr=data_addr, mmio_we=datamem_wr, mmio_wdata={data_out3,data_out2,data_out1,data_out0}. Go to REQ.
  - REQ: mmio_req=1 and dmem_wait=1; outputs are held stable. On mmio_ack=1, latch mmio_rdata into data_in (0 for writes), drop mmio_req, go to DONE.
  - DONE: dmem_wait=0 for one cycle so the core advances; data_in holds the MMIO result. Go to IDLE.
  - The new access, if any, is evaluated in IDLE the following cycle. The core must not present the same MMIO access twice; this is guaranteed by the core advancing in DONE.
- mmio_ack outside REQ is ignored.
- RAM and HOLE accesses never assert dmem_wait and are not processed while the FSM is in REQ. Write strobes are suppressed while dmem_wait=1 for any RAM address.
- Reset asserted mid-transaction: FSM returns to IDLE immediately; mmio_req and dmem_wait drop asynchronously. A later mmio_ack is ignored.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to REQ and increments each REQ cycle.
  - If it reaches TIMEOUT without mmio_ack: drop mmio_req, set data_in=32'hDEAD_BEEF, pulse err, go to DONE.
- When undefined: no counter; REQ waits indefinitely for mmio_ack.

Test Plan:
- Reset then read RAM addr 0x0: dmem_wait=0, err=0, mmio_req=0.
  - Write 0xAABBCCDD to 0x10 with strobe 4'hF, then read 0x10 → data_in=0xAABBCCDD one cycle after the read address.
- Partial write: with word 0x10 = 0xAABBCCDD, write lane 1 with data_out1=0x55, strobe 4'b0010, same cycle as the read → next cycle data_in=0xAABB55DD (write-first bypass).
- MMIO read at 0x0001_0004, peripheral acks after 3 cycles with 0x12345678:
  - dmem_wait=1 from the address cycle through the ack cycle.
  - mmio_req high for 3 cycles, mmio_we=0.
  - DONE cycle: dmem_wait=0, data_in=0x12345678.
- MMIO write at 0x0001_0008, strobe 4'b1100, lanes 0x11/0x22/0x33/0x44 → mmio_wdata=0x44332211, mmio_we=4'b1100, held until ack; RAM unchanged.
- HOLE access at 0x0000_8000 with strobe 4'hF → err one-cycle pulse, data_in=0, no RAM change; rst asserted during REQ → mmio_req and dmem_wait=0 immediately.
- With DMEM_TIMEOUT_EN and TIMEOUT=16, MMIO read with no ack → after 16 REQ cycles mmio_req=0, err pulse, data_in=0xDEADBEEF, dmem_wait low for one DONE cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: on-chip word RAM with 1-cycle reads plus a req/ack MMIO bridge.
// Optional MMIO ack timeout is compiled in with `define DMEM_TIMEOUT_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [3:0]  datamem_wr,
    input  logic [7:0]  data_out0,
    input  logic [7:0]  data_out1,
    input  logic [7:0]  data_out2,
    input  logic [7:0]  data_out3,
    output logic [31:0] data_in,
    output logic        dmem_wait,
    output logic        mmio_req,
    output logic [3:0]  mmio_we,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_wdata,
    input  logic [31:0] mmio_rdata,
    input  logic        mmio_ack,
    output logic        err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          in_ram;
    logic          in_mmio;
    logic [AW-1:0] word_idx;
    logic [31:0]   wr_word;
    logic [31:0]   rd_word;
    logic [31:0]   merged;
    logic          ram_we;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;
`endif

    assign in_ram   = {1'b0, data_addr} < RAM_BYTES;
    assign in_mmio  = data_addr >= MMIO_BASE;
    assign word_idx = data_addr[AW+1:2];
    assign wr_word  = {data_out3, data_out2, data_out1, data_out0};
    assign rd_word  = mem[word_idx];

    // Write-first: the merged word feeds both the RAM write and the read data register.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (datamem_wr[i]) begin
                merged[8*i +: 8] = wr_word[8*i +: 8];
            end
        end
    end

    assign ram_we    = !rst && (state == S_IDLE) && in_ram && (|datamem_wr);
    assign mmio_req  = (state == S_REQ);
    assign dmem_wait = !rst && (((state == S_IDLE) && in_mmio) || (state == S_REQ));

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            data_in    <= 32'h0;
            mmio_we    <= 4'h0;
            mmio_addr  <= 32'h0;
            mmio_wdata <= 32'h0;
            err        <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_mmio) begin
                        mmio_addr  <= data_addr;
                        mmio_we    <= datamem_wr;
                        mmio_wdata <= wr_word;
                        state      <= S_REQ;
`ifdef DMEM_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end else if (in_ram) begin
                        data_in <= merged;
                    end else begin
                        data_in <= 32'h0;
                        err     <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mmio_ack) begin
                        data_in <= (mmio_we == 4'h0) ? mmio_rdata : 32'h0;
                        state   <= S_DONE;
`ifdef DMEM_TIMEOUT_EN
                    end else if (to_cnt == CW'(TIMEOUT - 1)) begin
                        data_in <= 32'hDEAD_BEEF;
                        err     <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: driver pushes model results, monitor pops them.
// Define DMEM_TIMEOUT_EN for both bench and RTL to exercise the MMIO timeout path.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned NO_ACK  = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_addr = 32'h0;
    logic [3:0]  datamem_wr = 4'h0;
    logic [7:0]  data_out0 = 8'h0;
    logic [7:0]  data_out1 = 8'h0;
    logic [7:0]  data_out2 = 8'h0;
    logic [7:0]  data_out3 = 8'h0;
    logic [31:0] data_in;
    logic        dmem_wait;
    logic        mmio_req;
    logic [3:0]  mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata = 32'h0;
    logic        mmio_ack = 1'b0;
    logic        err;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .MMIO_BASE  (32'h0001_0000),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_addr (data_addr),
        .datamem_wr(datamem_wr),
        .data_out0 (data_out0),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .data_out3 (data_out3),
        .data_in   (data_in),
        .dmem_wait (dmem_wait),
        .mmio_req  (mmio_req),
        .mmio_we   (mmio_we),
        .mmio_addr (mmio_addr),
        .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata),
        .mmio_ack  (mmio_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        exp_q[$];
    logic [31:0] mem_m [DEPTH];
    bit          mon_en = 1'b0;

    int unsigned per_delay  = 0;
    logic [31:0] per_rdata  = 32'h0;
    logic [31:0] exp_maddr  = 32'h0;
    logic [3:0]  exp_mwe    = 4'h0;
    logic [31:0] exp_mwdata = 32'h0;

    int unsigned pool [19] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                               1021, 1022, 1023};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    // 0 = RAM, 1 = hole, 2 = MMIO
    function automatic int region(input logic [31:0] a);
        if (a < 32'(DEPTH * 4)) return 0;
        if (a >= 32'h0001_0000) return 2;
        return 1;
    endfunction

    task automatic abort_run(input string why);
        bad++;
        $display("FAIL %s: bound expired at %0t", why, $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the core may advance.
    task automatic issue(input logic [31:0] addr, input logic [3:0] wr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int unsigned delay);
        exp_t        e;
        int          r;
        int unsigned idx;
        int unsigned reqs;
        int unsigned budget;
        int unsigned exp_reqs;
        bit          done;
        r = region(addr);
        e.data = 32'h0;
        e.err  = 1'b0;
        exp_reqs = 0;
        if (r == 0) begin
            idx = int'(addr[11:2]);
            for (int i = 0; i < 4; i++) begin
                if (wr[i]) mem_m[idx][8*i +: 8] = wd[8*i +: 8];
            end
            e.data = mem_m[idx];
        end else if (r == 1) begin
            e.err = 1'b1;
        end else begin
            per_delay  = delay;
            per_rdata  = rdata;
            exp_maddr  = addr;
            exp_mwe    = wr;
            exp_mwdata = wd;
            if (delay >= NO_ACK) begin
                e.data   = 32'hDEAD_BEEF;
                e.err    = 1'b1;
                exp_reqs = TIMEOUT;
            end else begin
                e.data   = (wr == 4'h0) ? rdata : 32'h0;
                exp_reqs = delay + 1;
            end
        end
        exp_q.push_back(e);
        data_addr  = addr;
        datamem_wr = wr;
        {data_out3, data_out2, data_out1, data_out0} = wd;
        reqs   = 0;
        budget = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (mmio_req) reqs++;
            if (!dmem_wait) done = 1'b1;
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 100) abort_run("dmem_wait_bound");
        end
        if (r == 2) check("mmio_req_cycles", 32'(reqs), 32'(exp_reqs));
    endtask

    // Peripheral: acks after per_delay extra REQ cycles, spurious acks while idle.
    initial begin
        int unsigned pcnt;
        pcnt = 0;
        forever begin
            @(negedge clk);
            if (mmio_req) begin
                check("mmio_addr", mmio_addr, exp_maddr);
                check("mmio_we", 32'(mmio_we), 32'(exp_mwe));
                check("mmio_wdata", mmio_wdata, exp_mwdata);
                if (pcnt == per_delay) begin
                    mmio_ack   = 1'b1;
                    mmio_rdata = per_rdata;
                end else begin
                    mmio_ack   = 1'b0;
                    mmio_rdata = $urandom;
                end
                pcnt++;
            end else begin
                pcnt       = 0;
                mmio_ack   = ($urandom_range(7) == 0);
                mmio_rdata = $urandom;
            end
        end
    end

    // Monitor: a response is due after an accepted RAM/hole cycle, or when dmem_wait falls.
    initial begin
        bit   prev_acc;
        bit   prev_wait;
        exp_t e;
        prev_acc  = 1'b0;
        prev_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                prev_acc  = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if ((prev_wait && !dmem_wait) || prev_acc) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard: response with empty queue at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_in", data_in, e.data);
                        check("err", 32'(err), 32'(e.err));
                    end
                end
                prev_acc  = !dmem_wait && (region(data_addr) != 2);
                prev_wait = dmem_wait;
            end
        end
    end

    initial begin
        #2_000_000;
        abort_run("watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        int unsigned k;
        int unsigned waited;

        repeat (3) @(negedge clk);
        check("rst_data_in", data_in, 32'h0);
        check("rst_dmem_wait", 32'(dmem_wait), 32'h0);
        check("rst_mmio_req", 32'(mmio_req), 32'h0);
        check("rst_mmio_we", 32'(mmio_we), 32'h0);
        check("rst_mmio_addr", mmio_addr, 32'h0);
        check("rst_mmio_wdata", mmio_wdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_wait", 32'(dmem_wait), 32'h0);
        check("post_rst_req", 32'(mmio_req), 32'h0);
        check("post_rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 mon_en = 1'b1;

        foreach (pool[i]) issue(32'(pool[i] * 4), 4'hF, $urandom, 32'h0, 0);

        // Directed scenarios
        issue(32'h0000_0010, 4'hF, 32'hAABB_CCDD, 32'h0, 0);
        issue(32'h0000_0010, 4'h0, 32'h0, 32'h0, 0);
        issue(32'h0000_0010, 4'b0010, 32'h0000_5500, 32'h0, 0);
        issue(32'h0001_0004, 4'h0, 32'h0, 32'h1234_5678, 2);
        issue(32'h0001_0008, 4'b1100, 32'h4433_2211, 32'hCAFE_F00D, 1);
        issue(32'h0000_0010, 4'h0, 32'h0, 32'h0, 0);
        issue(32'h0000_8000, 4'hF, 32'hFFFF_FFFF, 32'h0, 0);
        issue(32'h0000_0000, 4'h0, 32'h0, 32'h0, 0);
        issue(32'h0000_0FFF, 4'h0, 32'h0, 32'h0, 0);
        issue(32'h0000_1000, 4'hF, 32'h0BAD_0BAD, 32'h0, 0);
        issue(32'h0000_FFFF, 4'h0, 32'h0, 32'h0, 0);
        issue(32'h0001_0000, 4'h0, 32'h0, 32'h5A5A_A5A5, 0);
        issue(32'hFFFF_FFFF, 4'hF, 32'h0102_0304, 32'h0, 4);
        issue(32'h0000_0000, 4'h0, 32'h0, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(99);
            w = ($urandom_range(9) < 3) ? 4'h0 : 4'($urandom_range(15));
            if (k < 60) begin
                a = 32'(pool[$urandom_range(18)] * 4) | 32'($urandom_range(3));
                issue(a, w, $urandom, 32'h0, 0);
            end else if (k < 75) begin
                a = 32'($urandom_range(32'h0000_FFFF, 32'h0000_1000));
                issue(a, w, $urandom, 32'h0, 0);
            end else begin
                a = 32'h0001_0000 + 32'($urandom_range(32'h00FF_FFFF));
                issue(a, w, $urandom, $urandom, $urandom_range(4));
            end
        end

        // Reset in the middle of an MMIO request
        issue(32'h0000_0000, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        #1 mon_en = 1'b0;
        check("queue_drained_pre_rst", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;
        per_delay  = NO_ACK;
        exp_maddr  = 32'h0001_0020;
        exp_mwe    = 4'h0;
        exp_mwdata = 32'h0;
        data_addr  = 32'h0001_0020;
        datamem_wr = 4'h0;
        {data_out3, data_out2, data_out1, data_out0} = 32'h0;
        waited = 0;
        @(negedge clk);
        while (!mmio_req) begin
            waited++;
            if (waited > 10) abort_run("mmio_req_bound");
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(mmio_req), 32'h0);
        check("rst_mid_wait", 32'(dmem_wait), 32'h0);
        check("rst_mid_data_in", data_in, 32'h0);
        check("rst_mid_err", 32'(err), 32'h0);
        data_addr = 32'h0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_req_idle", 32'(mmio_req), 32'h0);
            check("post_rst_wait_idle", 32'(dmem_wait), 32'h0);
        end
        exp_q.delete();
        @(posedge clk);
        #1 mon_en = 1'b1;

        foreach (pool[i]) issue(32'(pool[i] * 4), 4'h0, 32'h0, 32'h0, 0);
        issue(32'h0001_0040, 4'h3, 32'h7766_5544, 32'h0, 2);
        issue(32'h0000_0004, 4'b1001, 32'hEE00_00FF, 32'h0, 0);
        issue(32'h0000_0004, 4'h0, 32'h0, 32'h0, 0);

`ifdef DMEM_TIMEOUT_EN
        issue(32'h0001_0100, 4'h0, 32'h0, 32'h0, NO_ACK);
        issue(32'h0000_0010, 4'h0, 32'h0, 32'h0, 0);
`endif

        issue(32'h0000_0000, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        #1;
        check("queue_drained_end", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
